// File: rtl/router_pkt_tx.sv
`default_nettype none
// ============================================================================
// Module      : router_pkt_tx
// Description : Packet source for the router 1x3 input port. Accepts a
//               command (destination address + payload length), buffers the
//               whole payload from a byte stream, then transmits header,
//               payload and XOR parity back-to-back, stalling only on busy.
// Ports       : clock, resetn          - clock, synchronous active-low reset
//               cmd_valid/addr/len     - command request
//               cmd_ready              - high while idle
//               pl_data/pl_valid       - payload byte stream
//               pl_ready               - high while loading payload
//               busy                   - router back-pressure
//               pkt_valid, data_out    - registered router input bus
//               tx_active              - packet in progress
//               done, err_cmd          - one-cycle event pulses
//               last_parity, pkt_count - status of completed packets
// Revision    : 1.0 - initial release
// ============================================================================
module router_pkt_tx #(
    parameter int MAX_LEN    = 63,
    parameter int GAP_CYCLES = 2
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_addr,
    input  logic [5:0]  cmd_len,
    output logic        cmd_ready,
    input  logic [7:0]  pl_data,
    input  logic        pl_valid,
    output logic        pl_ready,
    input  logic        busy,
    output logic        pkt_valid,
    output logic [7:0]  data_out,
    output logic        tx_active,
    output logic        done,
    output logic        err_cmd,
    output logic [7:0]  last_parity,
    output logic [15:0] pkt_count
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOAD    = 3'd1;
    localparam logic [2:0] HEADER  = 3'd2;
    localparam logic [2:0] PAYLOAD = 3'd3;
    localparam logic [2:0] PARITY  = 3'd4;
    localparam logic [2:0] GAP     = 3'd5;

    logic [2:0] state;
    logic [7:0] header;
    logic [5:0] len;
    logic [7:0] parity;
    logic [5:0] cnt;
    logic [5:0] idx;
    logic [3:0] gap;
    logic [7:0] mem [0:MAX_LEN-1];

    logic cmd_bad;

    assign cmd_ready = (state == IDLE);
    assign pl_ready  = (state == LOAD);
    assign tx_active = (state != IDLE);

    assign cmd_bad = (cmd_addr == 2'b11) || (cmd_len == 6'd0) ||
                     ({1'b0, cmd_len} > 7'(MAX_LEN));

    // Payload buffer has no reset so it can map onto plain storage.
    always_ff @(posedge clock) begin
        if (resetn && (state == LOAD) && pl_valid) begin
            mem[cnt] <= pl_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state       <= IDLE;
            pkt_valid   <= 1'b0;
            data_out    <= 8'd0;
            done        <= 1'b0;
            err_cmd     <= 1'b0;
            last_parity <= 8'd0;
            pkt_count   <= 16'd0;
            header      <= 8'd0;
            len         <= 6'd0;
            parity      <= 8'd0;
            cnt         <= 6'd0;
            idx         <= 6'd0;
            gap         <= 4'd0;
        end else begin
            done    <= 1'b0;
            err_cmd <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_bad) begin
                            err_cmd <= 1'b1;
                        end else begin
                            header <= {cmd_len, cmd_addr};
                            len    <= cmd_len;
                            parity <= {cmd_len, cmd_addr};
                            cnt    <= 6'd0;
                            state  <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (pl_valid) begin
                        parity <= parity ^ pl_data;
                        cnt    <= cnt + 6'd1;
                        // Last byte loaded: header goes straight onto the bus.
                        if (cnt == 6'(len - 6'd1)) begin
                            data_out  <= header;
                            pkt_valid <= 1'b1;
                            state     <= HEADER;
                        end
                    end
                end
                HEADER: begin
                    if (!busy) begin
                        data_out <= mem[0];
                        idx      <= 6'd1;
                        state    <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (!busy) begin
                        if (idx == len) begin
                            data_out  <= parity;
                            pkt_valid <= 1'b0;
                            state     <= PARITY;
                        end else begin
                            data_out <= mem[idx];
                            idx      <= idx + 6'd1;
                        end
                    end
                end
                PARITY: begin
                    if (!busy) begin
                        data_out    <= 8'd0;
                        done        <= 1'b1;
                        last_parity <= parity;
                        pkt_count   <= pkt_count + 16'd1;
                        gap         <= 4'(GAP_CYCLES);
                        state       <= (GAP_CYCLES == 0) ? IDLE : GAP;
                    end
                end
                GAP: begin
                    // Leaves on the edge where the counter reaches zero.
                    gap <= gap - 4'd1;
                    if (gap <= 4'd1) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_pkt_tx
// Description : Directed self-checking bench for router_pkt_tx. Inputs are
//               driven and outputs sampled 1 time unit after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_pkt_tx;

    logic        clock = 1'b0;
    logic        resetn;
    logic        cmd_valid;
    logic [1:0]  cmd_addr;
    logic [5:0]  cmd_len;
    logic        cmd_ready;
    logic [7:0]  pl_data;
    logic        pl_valid;
    logic        pl_ready;
    logic        busy;
    logic        pkt_valid;
    logic [7:0]  data_out;
    logic        tx_active;
    logic        done;
    logic        err_cmd;
    logic [7:0]  last_parity;
    logic [15:0] pkt_count;

    int tests_run    = 0;
    int tests_failed = 0;

    router_pkt_tx #(.MAX_LEN(63), .GAP_CYCLES(2)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .cmd_valid   (cmd_valid),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .cmd_ready   (cmd_ready),
        .pl_data     (pl_data),
        .pl_valid    (pl_valid),
        .pl_ready    (pl_ready),
        .busy        (busy),
        .pkt_valid   (pkt_valid),
        .data_out    (data_out),
        .tx_active   (tx_active),
        .done        (done),
        .err_cmd     (err_cmd),
        .last_parity (last_parity),
        .pkt_count   (pkt_count)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check the bus byte and its valid flag, then advance one cycle.
    task automatic bus(input string tag, input logic [7:0] d, input logic pv);
        chk({tag, "_data"}, {8'd0, data_out}, {8'd0, d});
        chk({tag, "_pv"}, {15'd0, pkt_valid}, {15'd0, pv});
        step();
    endtask

    task automatic send_cmd(input logic [1:0] a, input logic [5:0] l);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic load(input logic [7:0] b);
        pl_valid = 1'b1;
        pl_data  = b;
        step();
        pl_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn    = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = 2'b00;
        cmd_len   = 6'd0;
        pl_data   = 8'd0;
        pl_valid  = 1'b0;
        busy      = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_pv", {15'd0, pkt_valid}, 16'd0);
        chk("rst_data", {8'd0, data_out}, 16'd0);
        chk("rst_cmd_ready", {15'd0, cmd_ready}, 16'd1);
        chk("rst_tx_active", {15'd0, tx_active}, 16'd0);
        chk("rst_cnt", pkt_count, 16'd0);
        chk("rst_lp", {8'd0, last_parity}, 16'd0);
        resetn = 1'b1;
        step();

        // Single byte packet: addr 01 len 1, payload AA
        send_cmd(2'b01, 6'd1);
        chk("t1_pl_ready", {15'd0, pl_ready}, 16'd1);
        chk("t1_cmd_ready", {15'd0, cmd_ready}, 16'd0);
        chk("t1_load_pv", {15'd0, pkt_valid}, 16'd0);
        load(8'hAA);
        bus("t1_hdr", 8'h05, 1'b1);
        bus("t1_pl0", 8'hAA, 1'b1);
        bus("t1_par", 8'hAF, 1'b0);
        chk("t1_done", {15'd0, done}, 16'd1);
        chk("t1_lp", {8'd0, last_parity}, 16'h00AF);
        chk("t1_cnt", pkt_count, 16'd1);
        chk("t1_post_data", {8'd0, data_out}, 16'd0);
        step();
        chk("t1_done_off", {15'd0, done}, 16'd0);
        chk("t1_gap_ready", {15'd0, cmd_ready}, 16'd0);
        step();
        chk("t1_ready", {15'd0, cmd_ready}, 16'd1);

        // Busy on header: addr 10 len 3, payload 11 22 33
        send_cmd(2'b10, 6'd3);
        load(8'h11);
        load(8'h22);
        load(8'h33);
        busy = 1'b1;
        bus("t2_hdr_a", 8'h0E, 1'b1);
        bus("t2_hdr_b", 8'h0E, 1'b1);
        busy = 1'b0;
        bus("t2_hdr_c", 8'h0E, 1'b1);
        bus("t2_pl0", 8'h11, 1'b1);
        bus("t2_pl1", 8'h22, 1'b1);
        bus("t2_pl2", 8'h33, 1'b1);
        bus("t2_par", 8'h0E, 1'b0);
        chk("t2_done", {15'd0, done}, 16'd1);
        chk("t2_cnt", pkt_count, 16'd2);
        step();
        step();
        chk("t2_ready", {15'd0, cmd_ready}, 16'd1);

        // Busy mid-payload: 22 held for 5 cycles
        send_cmd(2'b10, 6'd3);
        load(8'h11);
        load(8'h22);
        load(8'h33);
        bus("t3_hdr", 8'h0E, 1'b1);
        bus("t3_pl0", 8'h11, 1'b1);
        busy = 1'b1;
        for (int i = 0; i < 4; i++) bus("t3_hold", 8'h22, 1'b1);
        busy = 1'b0;
        bus("t3_pl1", 8'h22, 1'b1);
        bus("t3_pl2", 8'h33, 1'b1);
        bus("t3_par", 8'h0E, 1'b0);
        chk("t3_cnt", pkt_count, 16'd3);
        chk("t3_lp", {8'd0, last_parity}, 16'h000E);
        step();
        step();
        chk("t3_ready", {15'd0, cmd_ready}, 16'd1);

        // Illegal commands
        send_cmd(2'b11, 6'd5);
        chk("t4a_err", {15'd0, err_cmd}, 16'd1);
        chk("t4a_ready", {15'd0, cmd_ready}, 16'd1);
        chk("t4a_pv", {15'd0, pkt_valid}, 16'd0);
        chk("t4a_active", {15'd0, tx_active}, 16'd0);
        step();
        chk("t4a_err_off", {15'd0, err_cmd}, 16'd0);
        send_cmd(2'b00, 6'd0);
        chk("t4b_err", {15'd0, err_cmd}, 16'd1);
        chk("t4b_ready", {15'd0, cmd_ready}, 16'd1);
        step();
        chk("t4b_err_off", {15'd0, err_cmd}, 16'd0);
        chk("t4_cnt", pkt_count, 16'd3);

        // Max length with alternating pl_valid; XOR of 1..63 is 0
        send_cmd(2'b00, 6'd63);
        for (int i = 1; i <= 63; i++) begin
            load(8'(i));
            if (i < 63) begin
                chk("t5_load_pv", {15'd0, pkt_valid}, 16'd0);
                step();
            end
        end
        bus("t5_hdr", 8'hFC, 1'b1);
        for (int i = 1; i <= 63; i++) bus("t5_pl", 8'(i), 1'b1);
        bus("t5_par", 8'hFC, 1'b0);
        chk("t5_done", {15'd0, done}, 16'd1);
        chk("t5_cnt", pkt_count, 16'd4);
        chk("t5_gap0", {15'd0, cmd_ready}, 16'd0);
        step();
        chk("t5_gap1", {15'd0, cmd_ready}, 16'd0);
        step();
        chk("t5_ready", {15'd0, cmd_ready}, 16'd1);

        // Reset while third payload byte is on the bus
        send_cmd(2'b01, 6'd4);
        load(8'hA1);
        load(8'hB2);
        load(8'hC3);
        load(8'hD4);
        bus("t6_hdr", 8'h11, 1'b1);
        bus("t6_pl0", 8'hA1, 1'b1);
        bus("t6_pl1", 8'hB2, 1'b1);
        chk("t6_pl2_data", {8'd0, data_out}, 16'h00C3);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        chk("t6_rst_pv", {15'd0, pkt_valid}, 16'd0);
        chk("t6_rst_data", {8'd0, data_out}, 16'd0);
        chk("t6_rst_ready", {15'd0, cmd_ready}, 16'd1);
        chk("t6_rst_cnt", pkt_count, 16'd0);
        chk("t6_rst_lp", {8'd0, last_parity}, 16'd0);

        // Following legal packet: addr 00 len 2, payload 5A 3C, parity 6E
        send_cmd(2'b00, 6'd2);
        load(8'h5A);
        load(8'h3C);
        bus("t7_hdr", 8'h08, 1'b1);
        bus("t7_pl0", 8'h5A, 1'b1);
        bus("t7_pl1", 8'h3C, 1'b1);
        bus("t7_par", 8'h6E, 1'b0);
        chk("t7_done", {15'd0, done}, 16'd1);
        chk("t7_cnt", pkt_count, 16'd1);
        chk("t7_lp", {8'd0, last_parity}, 16'h006E);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
